// File: rtl/fft_frame_scheduler_if.sv
// Stream bundle between the pair source, the FFT scheduler and the butterfly pipeline.
// Signal names carry the scheduler's port direction prefix so both ends read the same way.
interface fft_frame_scheduler_if #(
  parameter int DATA_W = 32
);
  logic                     i_src_valid;
  logic                     o_src_ready;
  logic signed [DATA_W-1:0] i_a_real;
  logic signed [DATA_W-1:0] i_a_imag;
  logic signed [DATA_W-1:0] i_b_real;
  logic signed [DATA_W-1:0] i_b_imag;
  logic                     o_pipe_valid;
  logic signed [DATA_W-1:0] o_a_real;
  logic signed [DATA_W-1:0] o_a_imag;
  logic signed [DATA_W-1:0] o_b_real;
  logic signed [DATA_W-1:0] o_b_imag;
  logic                     i_pipe_valid;

  modport slave (
    input  i_src_valid, i_a_real, i_a_imag, i_b_real, i_b_imag, i_pipe_valid,
    output o_src_ready, o_pipe_valid, o_a_real, o_a_imag, o_b_real, o_b_imag
  );

  modport master (
    output i_src_valid, i_a_real, i_a_imag, i_b_real, i_b_imag, i_pipe_valid,
    input  o_src_ready, o_pipe_valid, o_a_real, o_a_imag, o_b_real, o_b_imag
  );
endinterface

// File: rtl/fft_frame_scheduler.sv
// Admits whole FFT frames of butterfly pairs into the pipeline, limiting how many
// frames are in flight and counting pipeline outputs to retire completed frames.
module fft_frame_scheduler #(
  parameter int PAIRS_PER_FRAME = 512,
  parameter int MAX_INFLIGHT    = 2
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_enable,
  fft_frame_scheduler_if.slave  bus,
  output logic                  o_frame_in_done,
  output logic                  o_frame_out_done,
  output logic [1:0]            o_inflight,
  output logic                  o_busy,
  output logic                  o_err_unexpected
);
  localparam int              CNT_W = $clog2(PAIRS_PER_FRAME);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PAIRS_PER_FRAME - 1);
  localparam logic [1:0]      MAX_I = 2'(MAX_INFLIGHT);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_in_cnt, r_out_cnt;
  logic [1:0]        r_inflight;
  logic              r_in_done, r_out_done, r_err;
  logic              w_src_ready, w_accept, w_inc, w_dec, w_out_ev;
  logic              r_vld_p1;
  logic signed [31:0] r_a_real_p1, r_a_imag_p1, r_b_real_p1, r_b_imag_p1;

  // A new frame may only start while enabled; a frame already started always completes.
  always_comb begin
    w_state_nxt = r_state;
    w_src_ready = 1'b0;
    if (r_in_cnt != '0) begin
      w_src_ready = 1'b1;
    end else if (r_state == S_RUN && i_enable && r_inflight < MAX_I) begin
      w_src_ready = 1'b1;
    end
    case (r_state)
      S_IDLE:  if (i_enable) w_state_nxt = S_RUN;
      S_RUN:   if (!i_enable && r_in_cnt == '0) w_state_nxt = S_DRAIN;
      S_DRAIN: begin
        if (i_enable)              w_state_nxt = S_RUN;
        else if (r_inflight == '0) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_accept = bus.i_src_valid & w_src_ready;
  assign w_inc    = w_accept && (r_in_cnt == '0);
  assign w_out_ev = bus.i_pipe_valid && (r_inflight != '0);
  assign w_dec    = w_out_ev && (r_out_cnt == LAST);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state    <= S_IDLE;
      r_in_cnt   <= '0;
      r_out_cnt  <= '0;
      r_inflight <= '0;
      r_in_done  <= 1'b0;
      r_out_done <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_in_done  <= w_accept && (r_in_cnt == LAST);
      r_out_done <= w_dec;
      if (w_accept)  r_in_cnt  <= (r_in_cnt == LAST) ? '0 : r_in_cnt + CNT_W'(1);
      if (w_out_ev)  r_out_cnt <= (r_out_cnt == LAST) ? '0 : r_out_cnt + CNT_W'(1);
      if (w_inc && !w_dec)      r_inflight <= r_inflight + 2'd1;
      else if (w_dec && !w_inc) r_inflight <= r_inflight - 2'd1;
      if (bus.i_pipe_valid && r_inflight == '0) r_err <= 1'b1;
    end
  end

  // Stage p0 -> p1: accepted pair registered toward the first butterfly stage.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_vld_p1    <= 1'b0;
      r_a_real_p1 <= '0;
      r_a_imag_p1 <= '0;
      r_b_real_p1 <= '0;
      r_b_imag_p1 <= '0;
    end else begin
      r_vld_p1 <= w_accept;
      if (w_accept) begin
        r_a_real_p1 <= bus.i_a_real;
        r_a_imag_p1 <= bus.i_a_imag;
        r_b_real_p1 <= bus.i_b_real;
        r_b_imag_p1 <= bus.i_b_imag;
      end
    end
  end

  assign bus.o_src_ready  = w_src_ready;
  assign bus.o_pipe_valid = r_vld_p1;
  assign bus.o_a_real     = r_a_real_p1;
  assign bus.o_a_imag     = r_a_imag_p1;
  assign bus.o_b_real     = r_b_real_p1;
  assign bus.o_b_imag     = r_b_imag_p1;
  assign o_frame_in_done  = r_in_done;
  assign o_frame_out_done = r_out_done;
  assign o_inflight       = r_inflight;
  assign o_busy           = (r_state != S_IDLE);
  assign o_err_unexpected = r_err;
endmodule
